alu_ctrl_fsm: RTL
=================

Name: alu_ctrl_fsm

Overview:
- Multi-cycle controller that feeds the 4-bit combinational ALU (sel 00 AND, 01 OR, 10 XOR, 11 ADD).
- Accepts 10-bit instructions over a valid/ready handshake and holds a 4x4-bit register file.
- Drives the ALU operands and select, captures the ALU result and flags, writes the result back, then signals completion.
- Sits directly upstream of the ALU and consumes the ALU's outputs.

Parameters:
- DATA_W, 4, datapath width; fixed at 4 to match the ALU; other values unsupported.
- NUM_REGS, 4, register file depth; fixed at 4 (2-bit register fields).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- instr_valid  input  1  instruction present on instr.
- instr_ready  output  1  controller can accept an instruction.
- instr  input  10  [9:8] class, [7:6] alu sel, [5:4] rd, [3:2] rs, [1:0] rt; for LDI, imm = [3:0].
- alu_a  output  4  ALU operand a (registered).
- alu_b  output  4  ALU operand b (registered).
- alu_sel  output  2  ALU select (registered).
- alu_out  input  4  ALU result.
- alu_carry  input  1  ALU carry_out.
- alu_zero  input  1  ALU zero_flag.
- alu_ovf  input  1  ALU overflow_flag.
- result  output  4  last value written to the register file.
- flags  output  3  {carry, zero, overflow} from the last ALU instruction.
- done  output  1  one-cycle pulse when an instruction retires.
- illegal  output  1  one-cycle pulse, asserted with done, when class = 11.
- dbg_addr  input  2  register file debug read address.
- dbg_data  output  4  combinational read of reg[dbg_addr].

Behaviour:
- Reset (rst_n low at a rising edge): state = IDLE; all registers, alu_a, alu_b, alu_sel, result and flags cleared to 0; done = 0; illegal = 0; instr_ready = 1 after the reset edge.
- Reset mid-operation: the in-flight instruction is discarded, with no writeback and no done pulse.
- States and transitions:
  - IDLE: instr_ready = 1. On instr_valid & instr_ready, capture instr into IR; go to DECODE.
  - DECODE: instr_ready = 0. Class 00 (ALU): alu_a <= reg[rs], alu_b <= reg[rt], alu_sel <= IR[7:6]; go to EXEC. Class 01 (LDI), 10 (NOP) and 11 (illegal): go to WB.
  - EXEC: alu_a, alu_b and alu_sel are stable for the whole cycle. Latch alu_out, alu_carry, alu_zero and alu_ovf into internal holding registers; go to WB.
  - WB:
    - ALU: reg[rd] <= held result; result <= held result; flags <= held flags.
    - LDI: reg[rd] <= imm; result <= imm; flags unchanged.
    - NOP: no state change.
    - Illegal: no state change; illegal = 1.
    - All classes: done = 1 for this cycle; go to IDLE.
- Latency:
  - Handshake at edge N → done high in cycle N+3 for ALU instructions (DECODE, EXEC, WB).
  - Handshake at edge N → done high in cycle N+2 for LDI, NOP and illegal (DECODE, WB).
  - Next accept is possible at the edge that ends the WB cycle, so instr_ready is high again in the cycle after done.
- Handshake:
  - instr_ready is a registered function of state; it never depends combinationally on instr_valid.
  - instr_valid while instr_ready = 0 is ignored; the source must hold the instruction.
- Operand hazards: rd may equal rs or rt. Reads in DECODE see the value before this instruction's WB, so reg[0] = reg[0] + reg[0] doubles correctly.
- Arithmetic:
  - Carry and overflow are taken from the ALU, never recomputed here.
  - ADD wraps modulo 16.
  - Logic ops set carry = 0 and overflow = 0 as reported by the ALU.
- dbg_data: combinational read; a write at a clock edge is visible after that edge.
- Outputs are held between instructions; done and illegal are 0 outside WB.

Test Plan:
- Reset: assert rst_n = 0 for 2 cycles mid-EXEC → no done pulse; all regs, flags and result = 0; instr_ready = 1.
- LDI: LDI r1,#9 then LDI r2,#8 → dbg r1 = 9, r2 = 8; each done pulse 2 cycles after its accept; flags = 000.
- ADD overflow: r1 = 9, r2 = 8; ADD r3,r1,r2 → alu_a = 9, alu_b = 8, alu_sel = 11 in EXEC; r3 = 1; flags = {1,0,1}; done 3 cycles after accept.
- Signed overflow without carry: r1 = 7, r2 = 1; ADD r0,r1,r2 → r0 = 8; flags = {0,0,1}.
- Zero flag and rd = rs: r1 = 5; XOR r1,r1,r1 → r1 = 0; flags = {0,1,0}.
- Illegal and backpressure: class 11 instruction → illegal and done pulse together; regs and flags unchanged. instr_valid held high throughout → exactly one accept per instruction; instr_ready low in DECODE, EXEC and WB.

Source files
------------

// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle controller for a 4-bit combinational ALU: accepts 10-bit instructions,
// sequences DECODE/EXEC/WB, keeps a 4x4 register file and reports result and flags.
module alu_ctrl_fsm #(
  parameter int DATA_W   = 4,
  parameter int NUM_REGS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [9:0]        instr,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry,
  input  logic              alu_zero,
  input  logic              alu_ovf,
  output logic [DATA_W-1:0] result,
  output logic [2:0]        flags,
  output logic              done,
  output logic              illegal,
  input  logic [1:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_t;

  localparam logic [1:0] CLS_ALU = 2'b00;
  localparam logic [1:0] CLS_LDI = 2'b01;
  localparam logic [1:0] CLS_NOP = 2'b10;
  localparam logic [1:0] CLS_ILL = 2'b11;

  state_t            state_q, state_d;
  logic [9:0]        ir_q, ir_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [1:0]        alu_sel_q, alu_sel_d;
  logic [DATA_W-1:0] hold_out_q, hold_out_d;
  logic [2:0]        hold_flags_q, hold_flags_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [2:0]        flags_q, flags_d;
  logic              done_q, done_d;
  logic              illegal_q, illegal_d;
  logic              instr_ready_q, instr_ready_d;

  logic [1:0] ir_cls_s;
  logic [1:0] ir_rd_s;
  logic [1:0] ir_rs_s;
  logic [1:0] ir_rt_s;

  assign ir_cls_s = ir_q[9:8];
  assign ir_rd_s  = ir_q[5:4];
  assign ir_rs_s  = ir_q[3:2];
  assign ir_rt_s  = ir_q[1:0];

  // Next-state and next-output computation for every flop
  always_comb begin
    state_d       = state_q;
    ir_d          = ir_q;
    regs_d        = regs_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_sel_d     = alu_sel_q;
    hold_out_d    = hold_out_q;
    hold_flags_d  = hold_flags_q;
    result_d      = result_q;
    flags_d       = flags_q;

    case (state_q)
      S_IDLE: begin
        if (instr_valid && instr_ready_q) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DECODE: begin
        // Operands are read before this instruction's writeback, so rd == rs/rt is safe
        if (ir_cls_s == CLS_ALU) begin
          alu_a_d   = regs_q[ir_rs_s];
          alu_b_d   = regs_q[ir_rt_s];
          alu_sel_d = ir_q[7:6];
          state_d   = S_EXEC;
        end else begin
          state_d   = S_WB;
        end
      end
      S_EXEC: begin
        hold_out_d   = alu_out;
        hold_flags_d = {alu_carry, alu_zero, alu_ovf};
        state_d      = S_WB;
      end
      S_WB: begin
        case (ir_cls_s)
          CLS_ALU: begin
            regs_d[ir_rd_s] = hold_out_q;
            result_d        = hold_out_q;
            flags_d         = hold_flags_q;
          end
          CLS_LDI: begin
            regs_d[ir_rd_s] = ir_q[3:0];
            result_d        = ir_q[3:0];
          end
          CLS_NOP: begin
            result_d = result_q;
          end
          CLS_ILL: begin
            result_d = result_q;
          end
          default: begin
            result_d = result_q;
          end
        endcase
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status outputs are registered copies of what the next state implies
    instr_ready_d = (state_d == S_IDLE);
    done_d        = (state_d == S_WB);
    illegal_d     = (state_d == S_WB) && (ir_d[9:8] == CLS_ILL);
  end

  // Controller state, register file and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      ir_q          <= 10'd0;
      regs_q        <= '{default: '0};
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_sel_q     <= 2'd0;
      hold_out_q    <= '0;
      hold_flags_q  <= 3'd0;
      result_q      <= '0;
      flags_q       <= 3'd0;
      done_q        <= 1'b0;
      illegal_q     <= 1'b0;
      instr_ready_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      ir_q          <= ir_d;
      regs_q        <= regs_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_sel_q     <= alu_sel_d;
      hold_out_q    <= hold_out_d;
      hold_flags_q  <= hold_flags_d;
      result_q      <= result_d;
      flags_q       <= flags_d;
      done_q        <= done_d;
      illegal_q     <= illegal_d;
      instr_ready_q <= instr_ready_d;
    end
  end

  assign instr_ready = instr_ready_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_sel     = alu_sel_q;
  assign result      = result_q;
  assign flags       = flags_q;
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign dbg_data    = regs_q[dbg_addr];

endmodule
